// File: rtl/pipe_skid_stage.sv
// Elastic valid/ready stage with a one-beat skid buffer. in_ready and out_valid are both registered.
// Optional synchronous flush port, enabled by defining PIPE_SKID_FLUSH_EN.
//
// state | meaning
// ------+---------------------------------------------------------
// EMPTY | no beat held; out_valid=0, in_ready=1
// BUSY  | one beat in main register; out_valid=1, in_ready=1
// FULL  | main and skid both hold beats; out_valid=1, in_ready=0
module pipe_skid_stage #(
  parameter int unsigned     WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_FLUSH_EN
  ,
  input  logic             flush
`endif
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'b00,
    ST_BUSY  = 2'b01,
    ST_FULL  = 2'b10
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] main_q;
  logic [WIDTH-1:0] skid_q;
  logic             push;
  logic             pop;
  logic             load_main;
  logic             main_from_skid;
  logic             load_skid;
  logic             flush_act;

`ifdef PIPE_SKID_FLUSH_EN
  assign flush_act = flush;
`else
  assign flush_act = 1'b0;
`endif

  // Handshake outputs decode the state register only; the illegal code drives both low.
  assign in_ready  = (state == ST_EMPTY) || (state == ST_BUSY);
  assign out_valid = (state == ST_BUSY)  || (state == ST_FULL);
  assign out_data  = main_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  always_comb begin
    state_nxt      = state;
    load_main      = 1'b0;
    main_from_skid = 1'b0;
    load_skid      = 1'b0;
    unique case (state)
      ST_EMPTY: begin
        if (push) begin
          load_main = 1'b1;
          state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (push && pop) begin
          load_main = 1'b1;
        end else if (push) begin
          load_skid = 1'b1;
          state_nxt = ST_FULL;
        end else if (pop) begin
          state_nxt = ST_EMPTY;
        end
      end
      ST_FULL: begin
        if (pop) begin
          load_main      = 1'b1;
          main_from_skid = 1'b1;
          state_nxt      = ST_BUSY;
        end
      end
      default: state_nxt = ST_EMPTY;
    endcase
    // Flush discards whatever push or pop this cycle would have performed.
    if (flush_act) begin
      state_nxt      = ST_EMPTY;
      load_main      = 1'b0;
      main_from_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_q <= RESET_VALUE;
      skid_q <= RESET_VALUE;
    end else begin
      if (load_main) begin
        main_q <= main_from_skid ? skid_q : in_data;
      end
      if (load_skid) begin
        skid_q <= in_data;
      end
    end
  end

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Testbench for pipe_skid_stage: directed vector table, hand sequences for reset/flush,
// and random traffic compared against a two-entry queue model.
module tb_pipe_skid_stage;

  localparam int WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
`ifdef PIPE_SKID_FLUSH_EN
  logic             flush;
`endif

  int checks;
  int errors;

  pipe_skid_stage #(.WIDTH(WIDTH), .RESET_VALUE('0)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data)
`ifdef PIPE_SKID_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic             iv;
    logic [WIDTH-1:0] id;
    logic             ordy;
    logic             exp_ov;
    logic             exp_ir;
    logic [WIDTH-1:0] exp_od;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [WIDTH-1:0] act, input logic [WIDTH-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [WIDTH-1:0] id, input logic ordy,
                     input logic ov, input logic ir, input logic [WIDTH-1:0] od);
    vec_t v;
    v.iv = iv; v.id = id; v.ordy = ordy;
    v.exp_ov = ov; v.exp_ir = ir; v.exp_od = od;
    vecs.push_back(v);
  endtask

  task automatic drive_step(input logic iv, input logic [WIDTH-1:0] id, input logic ordy);
    @(negedge clk);
    in_valid  = iv;
    in_data   = id;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  logic [WIDTH-1:0] q[$];
  logic             m_push;
  logic             m_pop;
  logic             r_iv;
  logic             r_or;
  logic [WIDTH-1:0] r_d;

  initial begin
    checks    = 0;
    errors    = 0;
    reset     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
`ifdef PIPE_SKID_FLUSH_EN
    flush     = 1'b0;
`endif

    // reset held for 3 cycles
    repeat (3) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
    chk("reset_in_ready",  {31'b0, in_ready},  32'd1);
    chk("reset_out_data",  out_data,           32'h0);

    // streaming
    add(1, 32'h11, 1, 1, 1, 32'h11);
    add(1, 32'h22, 1, 1, 1, 32'h22);
    add(1, 32'h33, 1, 1, 1, 32'h33);
    add(1, 32'h44, 1, 1, 1, 32'h44);
    add(0, 32'h00, 1, 0, 1, 32'h44);
    // backpressure, 5 stalled cycles, then drain in order
    add(1, 32'hA1, 0, 1, 1, 32'hA1);
    add(1, 32'hA2, 0, 1, 0, 32'hA1);
    for (int i = 0; i < 5; i++) add(0, 32'h00, 0, 1, 0, 32'hA1);
    add(0, 32'h00, 1, 1, 1, 32'hA2);
    add(0, 32'h00, 1, 0, 1, 32'hA2);
    // simultaneous push and pop in BUSY
    add(1, 32'h05, 0, 1, 1, 32'h05);
    add(1, 32'h06, 1, 1, 1, 32'h06);
    add(0, 32'h00, 1, 0, 1, 32'h06);
    // push attempts while FULL are not accepted
    add(1, 32'hD1, 0, 1, 1, 32'hD1);
    add(1, 32'hD2, 0, 1, 0, 32'hD1);
    add(1, 32'hD3, 0, 1, 0, 32'hD1);
    add(1, 32'hD3, 1, 1, 1, 32'hD2);
    add(1, 32'hD3, 1, 1, 1, 32'hD3);
    add(0, 32'h00, 1, 0, 1, 32'hD3);

    for (int i = 0; i < vecs.size(); i++) begin
      drive_step(vecs[i].iv, vecs[i].id, vecs[i].ordy);
      chk($sformatf("vec%0d_out_valid", i), {31'b0, out_valid}, {31'b0, vecs[i].exp_ov});
      chk($sformatf("vec%0d_in_ready", i),  {31'b0, in_ready},  {31'b0, vecs[i].exp_ir});
      if (vecs[i].exp_ov)
        chk($sformatf("vec%0d_out_data", i), out_data, vecs[i].exp_od);
    end

    // asynchronous reset while FULL
    drive_step(1, 32'hB1, 0);
    drive_step(1, 32'hB2, 0);
    chk("full_b_in_ready", {31'b0, in_ready}, 32'd0);
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst_out_valid", {31'b0, out_valid}, 32'd0);
    chk("async_rst_in_ready",  {31'b0, in_ready},  32'd1);
    chk("async_rst_out_data",  out_data,           32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      drive_step(0, 32'h0, 1);
      chk($sformatf("post_rst_idle%0d", i), {31'b0, out_valid}, 32'd0);
    end

`ifdef PIPE_SKID_FLUSH_EN
    drive_step(1, 32'hC1, 0);
    drive_step(1, 32'hC2, 0);
    chk("full_c_in_ready", {31'b0, in_ready}, 32'd0);
    @(negedge clk);
    in_valid  = 1'b1;
    in_data   = 32'hC3;
    out_ready = 1'b1;
    flush     = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_out_valid", {31'b0, out_valid}, 32'd0);
    chk("flush_in_ready",  {31'b0, in_ready},  32'd1);
    @(negedge clk);
    flush    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive_step(0, 32'h0, 1);
      chk($sformatf("post_flush_idle%0d", i), {31'b0, out_valid}, 32'd0);
    end
`endif

    // random traffic against a two-entry FIFO model; stage is empty here
    q.delete();
    for (int n = 0; n < 3000; n++) begin
      r_iv = ($urandom_range(0, 99) < 60);
      r_or = ($urandom_range(0, 99) < 55);
      r_d  = $urandom;
      m_push = r_iv && (q.size() < 2);
      m_pop  = r_or && (q.size() > 0);
      drive_step(r_iv, r_d, r_or);
      if (m_pop)  void'(q.pop_front());
      if (m_push) q.push_back(r_d);
      chk("rand_out_valid", {31'b0, out_valid}, {31'b0, q.size() > 0});
      chk("rand_in_ready",  {31'b0, in_ready},  {31'b0, q.size() < 2});
      if (q.size() > 0) chk("rand_out_data", out_data, q[0]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipe_skid_stage.md
Name: pipe_skid_stage

Overview:
- Elastic valid/ready pipeline stage that sits directly upstream of the enable-gated flip-flop chains and pipeline registers.
- Converts a producer's valid/ready stream into registered data plus a registered valid that downstream registers can consume.
- Absorbs one beat of backpressure in a skid register, so ready is fully registered and never combinationally depends on out_ready.
- Sustains one beat per cycle with no bubbles.

Parameters:
- WIDTH, 32, payload width in bits.
- RESET_VALUE, 0, value loaded into the main and skid data registers on reset.

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  asynchronous, active-low reset; asserting it (0) clears state immediately, release is synchronous to clk.
- in_valid  input  1  producer has a beat on in_data.
- in_ready  output  1  stage accepts a beat this cycle; registered.
- in_data  input  WIDTH  producer payload.
- out_valid  output  1  out_data holds a valid beat; registered.
- out_ready  input  1  consumer takes the beat this cycle.
- out_data  output  WIDTH  payload; driven directly from the main register.

Behaviour:
- Push = in_valid && in_ready. Pop = out_valid && out_ready. Both are evaluated at the same posedge.
- Reset (reset=0, asynchronous):
  - state=EMPTY, out_valid=0, in_ready=1.
  - Main and skid registers = RESET_VALUE.
  - Reset mid-transfer drops all held beats; no beat is emitted after release until a new push.
- States are encoded 2-bit; in_ready and out_valid are decoded from registered state only.
  - EMPTY: out_valid=0, in_ready=1.
  - BUSY: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0.
- Transitions from EMPTY:
  - push -> main<=in_data, go to BUSY.
  - otherwise stay in EMPTY.
- Transitions from BUSY:
  - push && pop -> main<=in_data, stay in BUSY. This is the full-throughput case.
  - push && !pop -> skid<=in_data, go to FULL.
  - !push && pop -> go to EMPTY.
  - neither -> hold.
- Transitions from FULL:
  - pop -> main<=skid, go to BUSY.
  - !pop -> hold. No push is possible because in_ready=0.
- Latency: a beat pushed at edge N is visible on out_data/out_valid after edge N. Minimum latency is 1 cycle.
- Ordering: strict FIFO. The skid beat always leaves after the main beat.
- Stability:
  - While out_valid && !out_ready, out_data and out_valid hold unchanged.
  - While in a state with out_valid=0, out_data keeps its last value; consumers must ignore it.
- Producer rule: in_valid may rise or fall freely. A beat counts only when a push occurs.
- Unknown or illegal state encoding recovers to EMPTY on the next edge.
- Capacity: 2 beats. in_ready deasserts only in FULL.

Optional Feature:
- Macro: PIPE_SKID_FLUSH_EN.
- With the macro defined:
  - Adds input port flush (1 bit), synchronous and active-high.
  - On a posedge with flush=1: state<=EMPTY and any push or pop in that cycle is discarded.
  - Data registers keep their contents; they are not cleared.
  - Reset has priority over flush.
  - in_ready and out_valid do not depend on flush combinationally.
- Without the macro: no flush port; behaviour is exactly as above.

Test Plan:
- Reset: hold reset=0 for 3 cycles, then release.
  - Required: out_valid=0, in_ready=1, out_data=RESET_VALUE (0).
- Streaming: out_ready=1, push 0x11,0x22,0x33,0x44 on consecutive cycles.
  - Required: out_data shows 0x11..0x44 on the 4 cycles after each push, with no bubbles and in_ready constantly 1.
- Backpressure: push 0xA1 then 0xA2 with out_ready=0.
  - Required: after the 2nd push, state FULL and in_ready=0; out_data holds 0xA1 for 5 stalled cycles.
  - Raise out_ready: 0xA1 then 0xA2 pop in order, then out_valid=0.
- Simultaneous push and pop in BUSY: main=0x5, push 0x6 with out_ready=1.
  - Required: next cycle out_data=0x6, out_valid=1, state BUSY, no skid use.
- Reset mid-operation: FULL with 0xB1/0xB2, assert reset asynchronously between edges.
  - Required: out_valid falls to 0 immediately, not waiting for a clock edge; neither beat appears after release.
- PIPE_SKID_FLUSH_EN: FULL with 0xC1/0xC2, pulse flush=1 for one cycle while in_valid=1 with 0xC3.
  - Required: next cycle out_valid=0, in_ready=1, and 0xC3 is never output.
